// File: rtl/light_fsm.sv
// light_fsm: three-phase traffic-light sequencer (RED -> GREEN -> YELLOW -> RED).
// The light advances one phase when adv = en & light_cnt_last & second_cnt_pre_last
// is sampled high on a rising edge. It also supplies the external light counter
// with its reload value (phase duration - 1) for the phase now being shown.
//
// Optional build macro: LIGHT_FSM_FLASH_EN
//   defined   : while en = 0 the lamp flashes yellow, toggling between 3'b010 and
//               3'b000 on each edge where second_cnt_pre_last = 1 (first toggle
//               shows 3'b010). The state and light_cnt_init are held.
//   undefined : while en = 0 the lamp simply stays frozen at the current state.
//
// Ports:
//   clk                  rising-edge clock
//   rst_n                asynchronous reset, active HIGH despite the legacy name
//   en                   phase advance enable
//   light_cnt_last       light counter is on the last tick of the current phase
//   second_cnt_pre_last  seconds counter is one cycle before rollover
//   light                registered one-hot lamp drive (RED=100 YELLOW=010 GREEN=001)
//   light_cnt_init       registered reload value for the light counter
module light_fsm #(
  parameter int unsigned LIGHT_STATE_WIDTH = 3,
  parameter int unsigned RED_DUR           = 5,
  parameter int unsigned GREEN_DUR         = 4,
  parameter int unsigned YELLOW_DUR        = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         en,
  input  logic                         light_cnt_last,
  input  logic                         second_cnt_pre_last,
  output logic [LIGHT_STATE_WIDTH-1:0] light,
  output logic [LIGHT_STATE_WIDTH-1:0] light_cnt_init
);

  localparam int unsigned LSW = LIGHT_STATE_WIDTH;

  localparam logic [LSW-1:0] RED    = LSW'(3'b100);
  localparam logic [LSW-1:0] YELLOW = LSW'(3'b010);
  localparam logic [LSW-1:0] GREEN  = LSW'(3'b001);

  localparam logic [LSW-1:0] RED_INIT    = LSW'(RED_DUR - 1);
  localparam logic [LSW-1:0] GREEN_INIT  = LSW'(GREEN_DUR - 1);
  localparam logic [LSW-1:0] YELLOW_INIT = LSW'(YELLOW_DUR - 1);

  logic [LSW-1:0] light_current_state;
  logic [LSW-1:0] state_next;
  logic [LSW-1:0] light_d;
  logic [LSW-1:0] init_d;
  logic           adv;

`ifdef LIGHT_FSM_FLASH_EN
  localparam logic [LSW-1:0] DARK = LSW'(3'b000);

  // High while the flashing lamp is currently lit.
  logic flash_q;
  logic flash_d;
`endif

  // Reload value for the phase identified by a state encoding.
  function automatic logic [LSW-1:0] phase_init(input logic [LSW-1:0] s);
    logic [LSW-1:0] v;
    case (s)
      RED:     v = RED_INIT;
      GREEN:   v = GREEN_INIT;
      YELLOW:  v = YELLOW_INIT;
      default: v = RED_INIT;
    endcase
    return v;
  endfunction

  // State register.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      light_current_state <= RED;
    end else begin
      light_current_state <= state_next;
    end
  end

  // Next-state logic; any non one-hot code recovers to RED unconditionally.
  always_comb begin
    adv        = en & light_cnt_last & second_cnt_pre_last;
    state_next = light_current_state;
    case (light_current_state)
      RED:     if (adv) state_next = GREEN;
      GREEN:   if (adv) state_next = YELLOW;
      YELLOW:  if (adv) state_next = RED;
      default: state_next = RED;
    endcase
  end

  // Output logic; computed from the next state so outputs land on the same edge.
  always_comb begin
    light_d = state_next;
    init_d  = phase_init(state_next);
`ifdef LIGHT_FSM_FLASH_EN
    flash_d = 1'b0;
    if (!en) begin
      // Hold the lamp between seconds ticks, toggle it on each tick.
      flash_d = flash_q;
      light_d = light;
      if (second_cnt_pre_last) begin
        flash_d = ~flash_q;
        light_d = flash_q ? DARK : YELLOW;
      end
    end
`endif
  end

  // Output registers.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      light          <= RED;
      light_cnt_init <= RED_INIT;
`ifdef LIGHT_FSM_FLASH_EN
      flash_q        <= 1'b0;
`endif
    end else begin
      light          <= light_d;
      light_cnt_init <= init_d;
`ifdef LIGHT_FSM_FLASH_EN
      flash_q        <= flash_d;
`endif
    end
  end

endmodule

// File: tb/tb_light_fsm.sv
// tb_light_fsm: directed self-checking bench for light_fsm with default parameters.
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
module tb_light_fsm;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       light_cnt_last;
  logic       second_cnt_pre_last;
  logic [2:0] light;
  logic [2:0] light_cnt_init;

  int errors;
  int checks;

  light_fsm dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .en                  (en),
    .light_cnt_last      (light_cnt_last),
    .second_cnt_pre_last (second_cnt_pre_last),
    .light               (light),
    .light_cnt_init      (light_cnt_init)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to 1 unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic e, input logic lcl, input logic spl);
    en                  = e;
    light_cnt_last      = lcl;
    second_cnt_pre_last = spl;
  endtask

  task automatic test_reset();
    // Assert reset between edges: outputs must follow without a clock edge.
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (light !== 3'b100) begin errors++; $display("FAIL reset_async_light got=%b exp=100", light); end
    checks++;
    if (light_cnt_init !== 3'd4) begin errors++; $display("FAIL reset_async_init got=%0d exp=4", light_cnt_init); end
    tick();
    tick();
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (light !== 3'b100 || light_cnt_init !== 3'd4) begin
        errors++;
        $display("FAIL reset_hold[%0d] got=%b/%0d exp=100/4", i, light, light_cnt_init);
      end
    end
  endtask

  task automatic test_full_cycle();
    logic [2:0] exp_l [3];
    logic [2:0] exp_i [3];
    exp_l[0] = 3'b001; exp_i[0] = 3'd3;
    exp_l[1] = 3'b010; exp_i[1] = 3'd1;
    exp_l[2] = 3'b100; exp_i[2] = 3'd4;
    for (int p = 0; p < 3; p++) begin
      set_in(1'b1, 1'b1, 1'b1);
      tick();
      checks++;
      if (light !== exp_l[p] || light_cnt_init !== exp_i[p]) begin
        errors++;
        $display("FAIL cycle_step[%0d] got=%b/%0d exp=%b/%0d", p, light, light_cnt_init, exp_l[p], exp_i[p]);
      end
      set_in(1'b1, 1'b0, 1'b0);
      tick();
      tick();
      checks++;
      if (light !== exp_l[p] || light_cnt_init !== exp_i[p]) begin
        errors++;
        $display("FAIL cycle_hold[%0d] got=%b/%0d exp=%b/%0d", p, light, light_cnt_init, exp_l[p], exp_i[p]);
      end
    end
  endtask

  task automatic test_partial_qualifiers();
    // Step into GREEN first.
    set_in(1'b1, 1'b1, 1'b1);
    tick();
    checks++;
    if (light !== 3'b001) begin errors++; $display("FAIL partial_enter got=%b exp=001", light); end
    set_in(1'b1, 1'b1, 1'b0);
    tick();
    checks++;
    if (light !== 3'b001) begin errors++; $display("FAIL partial_last_only got=%b exp=001", light); end
    set_in(1'b1, 1'b0, 1'b1);
    tick();
    checks++;
    if (light !== 3'b001) begin errors++; $display("FAIL partial_pre_last_only got=%b exp=001", light); end
    set_in(1'b0, 1'b1, 1'b1);
    tick();
    checks++;
    if (light !== 3'b001 || light_cnt_init !== 3'd3) begin
      errors++;
      $display("FAIL partial_en_low got=%b/%0d exp=001/3", light, light_cnt_init);
    end
    set_in(1'b1, 1'b0, 1'b0);
    tick();
  endtask

  task automatic test_back_to_back();
    // From GREEN, two separate pulses return to RED.
    for (int i = 0; i < 2; i++) begin
      set_in(1'b1, 1'b1, 1'b1);
      tick();
      set_in(1'b1, 1'b0, 1'b0);
      tick();
    end
    checks++;
    if (light !== 3'b100) begin errors++; $display("FAIL b2b_start got=%b exp=100", light); end
    set_in(1'b1, 1'b1, 1'b1);
    tick();
    checks++;
    if (light !== 3'b001 || light_cnt_init !== 3'd3) begin
      errors++;
      $display("FAIL b2b_first got=%b/%0d exp=001/3", light, light_cnt_init);
    end
    tick();
    checks++;
    if (light !== 3'b010 || light_cnt_init !== 3'd1) begin
      errors++;
      $display("FAIL b2b_second got=%b/%0d exp=010/1", light, light_cnt_init);
    end
    set_in(1'b1, 1'b0, 1'b0);
    tick();
  endtask

  task automatic test_mid_reset();
    // Currently YELLOW; reset between edges.
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (light !== 3'b100 || light_cnt_init !== 3'd4) begin
      errors++;
      $display("FAIL mid_reset got=%b/%0d exp=100/4", light, light_cnt_init);
    end
    checks++;
    if (dut.light_current_state !== 3'b100) begin
      errors++;
      $display("FAIL mid_reset_state got=%b exp=100", dut.light_current_state);
    end
    tick();
    rst_n = 1'b0;
    tick();
    set_in(1'b1, 1'b1, 1'b1);
    tick();
    checks++;
    if (light !== 3'b001 || light_cnt_init !== 3'd3) begin
      errors++;
      $display("FAIL mid_reset_next got=%b/%0d exp=001/3", light, light_cnt_init);
    end
    set_in(1'b1, 1'b0, 1'b0);
    tick();
  endtask

  task automatic test_en_low();
    // In GREEN; en low with three seconds ticks (light_cnt_last held high too).
    logic [2:0] exp_l [3];
`ifdef LIGHT_FSM_FLASH_EN
    exp_l[0] = 3'b010; exp_l[1] = 3'b000; exp_l[2] = 3'b010;
`else
    exp_l[0] = 3'b001; exp_l[1] = 3'b001; exp_l[2] = 3'b001;
`endif
    for (int i = 0; i < 3; i++) begin
      set_in(1'b0, 1'b1, 1'b1);
      tick();
      checks++;
      if (light !== exp_l[i] || light_cnt_init !== 3'd3) begin
        errors++;
        $display("FAIL en_low[%0d] got=%b/%0d exp=%b/3", i, light, light_cnt_init, exp_l[i]);
      end
      set_in(1'b0, 1'b0, 1'b0);
      tick();
      checks++;
      if (light !== exp_l[i]) begin
        errors++;
        $display("FAIL en_low_gap[%0d] got=%b exp=%b", i, light, exp_l[i]);
      end
    end
    checks++;
    if (dut.light_current_state !== 3'b001) begin
      errors++;
      $display("FAIL en_low_state got=%b exp=001", dut.light_current_state);
    end
    set_in(1'b1, 1'b0, 1'b0);
    tick();
    checks++;
    if (light !== 3'b001 || light_cnt_init !== 3'd3) begin
      errors++;
      $display("FAIL en_restore got=%b/%0d exp=001/3", light, light_cnt_init);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst_n  = 1'b0;
    set_in(1'b1, 1'b0, 1'b0);
    test_reset();
    test_full_cycle();
    test_partial_qualifiers();
    test_back_to_back();
    test_mid_reset();
    test_en_low();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
